// File: rtl/thread_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// thread_regfile : per-thread register file with load scoreboard and LSU
//                  write-back port.  Rev 1.0
// ----------------------------------------------------------------------------
module thread_regfile #(
   parameter  int DATA_BITS         = 8,
   parameter  int NUM_REGS          = 16,
   parameter  int THREADS_PER_BLOCK = 4,
   parameter  int THREAD_ID         = 0,
   localparam int ADDR_BITS         = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 block_start,
   input  logic [DATA_BITS-1:0] block_id,
   input  logic [2:0]           core_state,
   input  logic [ADDR_BITS-1:0] decoded_rd_address,
   input  logic [ADDR_BITS-1:0] decoded_rs_address,
   input  logic [ADDR_BITS-1:0] decoded_rt_address,
   input  logic                 decoded_reg_write_enable,
   input  logic [1:0]           decoded_reg_input_mux,
   input  logic [DATA_BITS-1:0] decoded_immediate,
   input  logic [DATA_BITS-1:0] alu_out,
   input  logic                 lsu_wb_valid,
   input  logic [ADDR_BITS-1:0] lsu_wb_rd,
   input  logic [DATA_BITS-1:0] lsu_wb_data,
   output logic                 lsu_wb_ready,
   output logic [DATA_BITS-1:0] rs,
   output logic [DATA_BITS-1:0] rt,
   output logic                 operands_valid,
   output logic                 stall,
   output logic                 pending_any,
   output logic                 protocol_error
);

   localparam logic [2:0]           c_REQUEST   = 3'b011;
   localparam logic [2:0]           c_UPDATE    = 3'b110;
   localparam logic [1:0]           c_MUX_MEM   = 2'b01;
   localparam logic [ADDR_BITS-1:0] c_BLOCK_IDX = ADDR_BITS'(NUM_REGS - 3);
   localparam int                   c_NUM_FREE  = NUM_REGS - 3;

   logic [DATA_BITS-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]  r_pending;
   logic [DATA_BITS-1:0] r_rs;
   logic [DATA_BITS-1:0] r_rt;
   logic                 r_operands_valid;
   logic                 r_protocol_error;

   logic                 w_request;
   logic                 w_rd_ro;
   logic                 w_update_we;
   logic                 w_waw;
   logic                 w_data_write;
   logic                 w_load_issue;
   logic [DATA_BITS-1:0] w_wdata;
   logic                 w_src_hazard;
   logic                 w_wb_fire;
   logic                 w_wb_good;
   logic                 w_wb_bad;

   assign w_request    = enable & (core_state == c_REQUEST);
   assign w_rd_ro      = decoded_rd_address >= c_BLOCK_IDX;
   assign w_update_we  = enable & (core_state == c_UPDATE) & decoded_reg_write_enable & ~w_rd_ro;
   assign w_waw        = w_update_we & r_pending[decoded_rd_address];
   // mux 00 (ALU) and 10 (CONST) both write data now; bit 1 selects the source
   assign w_data_write = w_update_we & ~w_waw & ~decoded_reg_input_mux[0];
   assign w_load_issue = w_update_we & ~w_waw & (decoded_reg_input_mux == c_MUX_MEM);
   assign w_wdata      = decoded_reg_input_mux[1] ? decoded_immediate : alu_out;
   assign w_src_hazard = w_request & (r_pending[decoded_rs_address] | r_pending[decoded_rt_address]);

   assign stall        = w_src_hazard | w_waw;
   assign lsu_wb_ready = enable & ~(w_data_write & (decoded_rd_address == lsu_wb_rd));
   assign w_wb_fire    = lsu_wb_valid & lsu_wb_ready;
   assign w_wb_good    = w_wb_fire & r_pending[lsu_wb_rd];
   assign w_wb_bad     = w_wb_fire & ~r_pending[lsu_wb_rd];

   assign pending_any    = |r_pending;
   assign rs             = r_rs;
   assign rt             = r_rt;
   assign operands_valid = r_operands_valid;
   assign protocol_error = r_protocol_error;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[NUM_REGS-2] <= DATA_BITS'(THREADS_PER_BLOCK);
         r_regs[NUM_REGS-1] <= DATA_BITS'(THREAD_ID);
      end else if (enable) begin
         if (block_start) begin
            r_regs[NUM_REGS-3] <= block_id;
         end
         // lsu_wb_ready already excludes a data write and write-back to one register
         for (int i = 0; i < c_NUM_FREE; i++) begin
            if (w_wb_good && (lsu_wb_rd == ADDR_BITS'(i))) begin
               r_regs[i] <= lsu_wb_data;
            end else if (w_data_write && (decoded_rd_address == ADDR_BITS'(i))) begin
               r_regs[i] <= w_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending        <= '0;
         r_protocol_error <= 1'b0;
      end else begin
         for (int i = 0; i < c_NUM_FREE; i++) begin
            if (w_load_issue && (decoded_rd_address == ADDR_BITS'(i))) begin
               r_pending[i] <= 1'b1;
            end else if (w_wb_good && (lsu_wb_rd == ADDR_BITS'(i))) begin
               r_pending[i] <= 1'b0;
            end
         end
         if (w_wb_bad) begin
            r_protocol_error <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rs             <= '0;
         r_rt             <= '0;
         r_operands_valid <= 1'b0;
      end else begin
         r_operands_valid <= w_request & ~w_src_hazard;
         if (w_request && !w_src_hazard) begin
            r_rs <= r_regs[decoded_rs_address];
            r_rt <= r_regs[decoded_rt_address];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_thread_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_thread_regfile : directed self-checking bench for thread_regfile.
// ----------------------------------------------------------------------------
module tb_thread_regfile;

   localparam int DB = 8;
   localparam int AB = 4;
   localparam logic [2:0] REQ = 3'b011;
   localparam logic [2:0] UPD = 3'b110;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          block_start;
   logic [DB-1:0] block_id;
   logic [2:0]    core_state;
   logic [AB-1:0] rd_a, rs_a, rt_a;
   logic          we;
   logic [1:0]    mux;
   logic [DB-1:0] imm;
   logic [DB-1:0] alu_out;
   logic          wb_valid;
   logic [AB-1:0] wb_rd;
   logic [DB-1:0] wb_data;
   logic          wb_ready;
   logic [DB-1:0] rs, rt;
   logic          ov, stall, pending_any, perr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   thread_regfile #(
      .DATA_BITS(8), .NUM_REGS(16), .THREADS_PER_BLOCK(4), .THREAD_ID(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .block_start(block_start), .block_id(block_id), .core_state(core_state),
      .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
      .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
      .decoded_immediate(imm), .alu_out(alu_out),
      .lsu_wb_valid(wb_valid), .lsu_wb_rd(wb_rd), .lsu_wb_data(wb_data),
      .lsu_wb_ready(wb_ready), .rs(rs), .rt(rt), .operands_valid(ov),
      .stall(stall), .pending_any(pending_any), .protocol_error(perr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enable = 1'b1; block_start = 1'b0; core_state = 3'b000;
      we = 1'b0; mux = 2'b11; wb_valid = 1'b0;
   endtask

   task automatic request(input logic [AB-1:0] s, input logic [AB-1:0] t);
      idle(); core_state = REQ; rs_a = s; rt_a = t;
   endtask

   task automatic update(input logic [AB-1:0] d, input logic [1:0] m, input logic [DB-1:0] a, input logic [DB-1:0] k);
      idle(); core_state = UPD; we = 1'b1; rd_a = d; mux = m; alu_out = a; imm = k;
   endtask

   task automatic wb(input logic [AB-1:0] d, input logic [DB-1:0] v);
      wb_valid = 1'b1; wb_rd = d; wb_data = v;
   endtask

   task automatic test_reset();
      tests++; if (rs !== 8'h00) begin fails++; $display("FAIL reset_rs got %h exp 00", rs); end
      tests++; if (rt !== 8'h00) begin fails++; $display("FAIL reset_rt got %h exp 00", rt); end
      tests++; if ({ov, pending_any, perr, stall} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {ov, pending_any, perr, stall}); end
      reset_n = 1'b1;
      tick();
      request(4'd14, 4'd15); tick();
      tests++; if (rs !== 8'd4 || rt !== 8'd2) begin fails++; $display("FAIL reset_ro got %h/%h exp 04/02", rs, rt); end
      tests++; if (ov !== 1'b1) begin fails++; $display("FAIL reset_ov got %b exp 1", ov); end
      request(4'd13, 4'd0); tick();
      tests++; if (rs !== 8'd0 || rt !== 8'd0) begin fails++; $display("FAIL reset_blkidx got %h/%h exp 00/00", rs, rt); end
   endtask

   task automatic test_block_start();
      idle(); block_start = 1'b1; block_id = 8'd7; tick();
      idle(); block_id = 8'd9; tick();
      request(4'd13, 4'd0); tick();
      tests++; if (rs !== 8'd7 || ov !== 1'b1) begin fails++; $display("FAIL blk_read got %h ov %b exp 07 ov 1", rs, ov); end
      idle(); tick();
      tests++; if (ov !== 1'b0) begin fails++; $display("FAIL blk_ov_pulse got %b exp 0", ov); end
      request(4'd0, 4'd13); tick();
      tests++; if (rt !== 8'd7) begin fails++; $display("FAIL blk_hold got %h exp 07", rt); end
   endtask

   task automatic test_const_arith();
      update(4'd1, 2'b10, 8'h00, 8'h5A); tick();
      request(4'd1, 4'd15); tick();
      tests++; if (rs !== 8'h5A || rt !== 8'd2) begin fails++; $display("FAIL const_r1 got %h/%h exp 5a/02", rs, rt); end
      update(4'd14, 2'b10, 8'h00, 8'hFF); #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ro_stall got %b exp 0", stall); end
      tick();
      request(4'd14, 4'd14); tick();
      tests++; if (rs !== 8'd4 || perr !== 1'b0) begin fails++; $display("FAIL ro_ignore got %h err %b exp 04 err 0", rs, perr); end
      update(4'd2, 2'b00, 8'hC3, 8'h11); tick();
      request(4'd2, 4'd1); tick();
      tests++; if (rs !== 8'hC3 || rt !== 8'h5A) begin fails++; $display("FAIL alu_r2 got %h/%h exp c3/5a", rs, rt); end
   endtask

   task automatic test_load();
      update(4'd3, 2'b01, 8'h00, 8'h00); tick();
      tests++; if (pending_any !== 1'b1) begin fails++; $display("FAIL ldr_pending got %b exp 1", pending_any); end
      request(4'd3, 4'd0); #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ldr_stall got %b exp 1", stall); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (stall !== 1'b1 || ov !== 1'b0 || rs !== 8'hC3) begin fails++; $display("FAIL ldr_hold%0d got stall %b ov %b rs %h exp 1 0 c3", i, stall, ov, rs); end
      end
      wb(4'd3, 8'h33); #1;
      tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL ldr_ready got %b exp 1", wb_ready); end
      tick();
      wb_valid = 1'b0; #1;
      tests++; if (stall !== 1'b0 || pending_any !== 1'b0 || ov !== 1'b0) begin fails++; $display("FAIL ldr_done got stall %b pend %b ov %b exp 0 0 0", stall, pending_any, ov); end
      tick();
      tests++; if (rs !== 8'h33 || ov !== 1'b1) begin fails++; $display("FAIL ldr_data got %h ov %b exp 33 ov 1", rs, ov); end
   endtask

   task automatic test_waw();
      update(4'd4, 2'b01, 8'h00, 8'h00); tick();
      update(4'd4, 2'b00, 8'h44, 8'h00); wb(4'd4, 8'h99); #1;
      tests++; if (stall !== 1'b1 || wb_ready !== 1'b1) begin fails++; $display("FAIL waw_cycle got stall %b ready %b exp 1 1", stall, wb_ready); end
      tick();
      wb_valid = 1'b0; #1;
      tests++; if (stall !== 1'b0 || wb_ready !== 1'b0) begin fails++; $display("FAIL waw_retry got stall %b ready %b exp 0 0", stall, wb_ready); end
      tick();
      request(4'd4, 4'd0); tick();
      tests++; if (rs !== 8'h44 || perr !== 1'b0) begin fails++; $display("FAIL waw_final got %h err %b exp 44 err 0", rs, perr); end
   endtask

   task automatic test_back_to_back();
      update(4'd6, 2'b01, 8'h00, 8'h00); tick();
      update(4'd8, 2'b01, 8'h00, 8'h00); wb(4'd6, 8'h66); tick();
      tests++; if (pending_any !== 1'b1) begin fails++; $display("FAIL b2b_pending got %b exp 1", pending_any); end
      update(4'd7, 2'b10, 8'h00, 8'h77); wb(4'd8, 8'h88); #1;
      tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b exp 1", wb_ready); end
      tick();
      request(4'd6, 4'd8); tick();
      tests++; if (rs !== 8'h66 || rt !== 8'h88 || pending_any !== 1'b0) begin fails++; $display("FAIL b2b_loads got %h/%h pend %b exp 66/88 0", rs, rt, pending_any); end
      request(4'd7, 4'd6); tick();
      tests++; if (rs !== 8'h77) begin fails++; $display("FAIL b2b_const got %h exp 77", rs); end
   endtask

   task automatic test_enable();
      update(4'd9, 2'b01, 8'h00, 8'h00); tick();
      request(4'd9, 4'd9); enable = 1'b0; block_start = 1'b1; block_id = 8'd3; wb(4'd9, 8'h5F); #1;
      tests++; if (stall !== 1'b0 || wb_ready !== 1'b0) begin fails++; $display("FAIL en_low got stall %b ready %b exp 0 0", stall, wb_ready); end
      tick();
      tests++; if (ov !== 1'b0 || pending_any !== 1'b1) begin fails++; $display("FAIL en_hold got ov %b pend %b exp 0 1", ov, pending_any); end
      idle(); wb(4'd9, 8'h09); tick();
      request(4'd13, 4'd9); tick();
      tests++; if (rs !== 8'd7 || rt !== 8'h09) begin fails++; $display("FAIL en_resume got %h/%h exp 07/09", rs, rt); end
   endtask

   task automatic test_error();
      idle(); wb(4'd5, 8'hEE); tick();
      idle(); tick();
      tests++; if (perr !== 1'b1) begin fails++; $display("FAIL err_set got %b exp 1", perr); end
      request(4'd5, 4'd0); tick();
      idle(); tick(); tick();
      tests++; if (rs !== 8'h00 || perr !== 1'b1) begin fails++; $display("FAIL err_sticky got %h err %b exp 00 err 1", rs, perr); end
   endtask

   task automatic test_reset_midload();
      update(4'd10, 2'b01, 8'h00, 8'h00); tick();
      idle(); #2; reset_n = 1'b0; #1;
      tests++; if (pending_any !== 1'b0 || perr !== 1'b0) begin fails++; $display("FAIL rst_async got pend %b err %b exp 0 0", pending_any, perr); end
      tick(); reset_n = 1'b1;
      wb(4'd10, 8'hAA); tick();
      idle(); tick();
      tests++; if (perr !== 1'b1 || pending_any !== 1'b0) begin fails++; $display("FAIL rst_latewb got err %b pend %b exp 1 0", perr, pending_any); end
      request(4'd10, 4'd13); tick();
      tests++; if (rs !== 8'h00 || rt !== 8'h00) begin fails++; $display("FAIL rst_reg got %h/%h exp 00/00", rs, rt); end
   endtask

   initial begin
      reset_n = 1'b0; block_id = '0; rd_a = '0; rs_a = '0; rt_a = '0;
      imm = '0; alu_out = '0; wb_rd = '0; wb_data = '0;
      idle();
      tick(); tick();
      test_reset();
      test_block_start();
      test_const_arith();
      test_load();
      test_waw();
      test_back_to_back();
      test_enable();
      test_error();
      test_reset_midload();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
